// File: rtl/riscv_dmem_mmio_pkg.sv
// Shared address map, STATUS bit layout and address decode for the data-side memory stage.
package riscv_mem_pkg;

    localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
    localparam logic [31:0] TXDATA_ADDR = MMIO_BASE;
    localparam logic [31:0] STATUS_ADDR = MMIO_BASE + 32'h4;
    localparam logic [31:0] CYCLE_ADDR  = MMIO_BASE + 32'h8;

    localparam int FULL_BIT  = 0;
    localparam int EMPTY_BIT = 1;
    localparam int OVF_BIT   = 2;
    localparam int COUNT_LSB = 8;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_TX,
        REG_STATUS,
        REG_CYCLE,
        REG_NONE
    } region_e;

    // Byte offset within a word is ignored; every region is word-aligned.
    function automatic region_e decode_addr(input logic [31:0] addr, input int unsigned ram_depth);
        logic [31:0] word_addr;
        word_addr = addr & 32'hFFFF_FFFC;
        if (!addr[31] && ({2'b00, addr[31:2]} < ram_depth))
            return REG_RAM;
        else if (word_addr == TXDATA_ADDR)
            return REG_TX;
        else if (word_addr == STATUS_ADDR)
            return REG_STATUS;
        else if (word_addr == CYCLE_ADDR)
            return REG_CYCLE;
        else
            return REG_NONE;
    endfunction

endpackage

// File: rtl/riscv_dmem_mmio_if.sv
// Core-side load/store bus plus the TX byte stream, bundled for the data memory stage.
interface riscv_dmem_mmio_if;
    logic        dmem_wren;
    logic [31:0] ALU_result;
    logic [31:0] dmem_data_in;
    logic [31:0] dmem_data_out;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output dmem_wren, ALU_result, dmem_data_in, tx_ready,
        input  dmem_data_out, tx_valid, tx_data
    );

    modport slave (
        input  dmem_wren, ALU_result, dmem_data_in, tx_ready,
        output dmem_data_out, tx_valid, tx_data
    );
endinterface

// File: rtl/riscv_dmem_mmio_tx_fifo.sv
// Byte FIFO behind the TXDATA register; registered output, no fall-through.
module riscv_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    input  logic                       tx_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    buf_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : buf_q[rd_ptr_q];

    // A push into a full FIFO is lost even when a pop frees a slot this cycle.
    assign push_ok = push && !full;
    assign pop     = !empty && tx_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push_ok) - CW'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) buf_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/riscv_dmem_mmio.sv
// Data memory stage: word RAM plus MMIO (TX FIFO, STATUS, CYCLE) with same-cycle reads.
// Define DMEM_CYCLE_CNT_EN to build the free-running CYCLE counter; otherwise CYCLE reads 0.
module riscv_dmem_mmio
    import riscv_mem_pkg::*;
#(
    parameter int unsigned RAM_DEPTH = 256,
    parameter int unsigned TX_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    riscv_dmem_mmio_if.slave  bus
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam int CW = $clog2(TX_DEPTH) + 1;

    region_e       region;
    logic          wr_ram;
    logic          wr_tx;
    logic          wr_status;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          ovf_q, ovf_d;
    logic [31:0]   status_w;
    logic [31:0]   cycle_val;
    logic [31:0]   mem_q [RAM_DEPTH];

    assign region    = decode_addr(bus.ALU_result, RAM_DEPTH);
    assign wr_ram    = bus.dmem_wren && (region == REG_RAM);
    assign wr_tx     = bus.dmem_wren && (region == REG_TX);
    assign wr_status = bus.dmem_wren && (region == REG_STATUS);

    // Contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (wr_ram) mem_q[bus.ALU_result[AW+1:2]] <= bus.dmem_data_in;
    end

    riscv_tx_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_tx),
        .push_data (bus.dmem_data_in[7:0]),
        .tx_valid  (bus.tx_valid),
        .tx_data   (bus.tx_data),
        .tx_ready  (bus.tx_ready),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (wr_status)
            ovf_d = 1'b0;
        else if (wr_tx && fifo_full)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

`ifdef DMEM_CYCLE_CNT_EN
    logic        wr_cycle;
    logic [31:0] cycle_q, cycle_d;

    assign wr_cycle = bus.dmem_wren && (region == REG_CYCLE);

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (wr_cycle) cycle_d = bus.dmem_data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cycle_q <= '0;
        else        cycle_q <= cycle_d;
    end

    assign cycle_val = cycle_q;
`else
    assign cycle_val = '0;
`endif

    always_comb begin
        status_w                   = '0;
        status_w[COUNT_LSB +: CW]  = fifo_count;
        status_w[OVF_BIT]          = ovf_q;
        status_w[EMPTY_BIT]        = fifo_empty;
        status_w[FULL_BIT]         = fifo_full;
    end

    always_comb begin
        bus.dmem_data_out = '0;
        case (region)
            REG_RAM:    bus.dmem_data_out = mem_q[bus.ALU_result[AW+1:2]];
            REG_STATUS: bus.dmem_data_out = status_w;
            REG_CYCLE:  bus.dmem_data_out = cycle_val;
            default:    bus.dmem_data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_riscv_dmem_mmio.sv
// Directed bench for riscv_dmem_mmio: RAM, TX FIFO, overflow, CYCLE and async reset.
module tb_riscv_dmem_mmio;
    import riscv_mem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    riscv_dmem_mmio_if bus ();

    riscv_dmem_mmio #(
        .RAM_DEPTH (256),
        .TX_DEPTH  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.dmem_wren    = 1'b1;
        bus.ALU_result   = a;
        bus.dmem_data_in = d;
        @(posedge clk);
        #1;
        bus.dmem_wren    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.ALU_result = a;
        #1;
        check(tag, bus.dmem_data_out, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset            = 1'b0;
        bus.dmem_wren    = 1'b0;
        bus.ALU_result   = '0;
        bus.dmem_data_in = '0;
        bus.tx_ready     = 1'b0;
        #2;
        check("rst_valid", {31'b0, bus.tx_valid}, 32'h0);
        check("rst_data", {24'b0, bus.tx_data}, 32'h0);
        rd("rst_status", STATUS_ADDR, 32'h0000_0002);
        rd("rst_cycle", CYCLE_ADDR, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // RAM
        wr(32'h0, 32'h1111_1111);
        wr(32'h14, 32'h1234_5678);
        wr(32'h10, 32'hDEAD_BEEF);
        rd("ram_rd", 32'h10, 32'hDEAD_BEEF);
        rd("ram_neighbour", 32'h14, 32'h1234_5678);
        rd("ram_byteoff", 32'h13, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.dmem_wren    = 1'b1;
        bus.ALU_result   = 32'h10;
        bus.dmem_data_in = 32'hCAFE_F00D;
        #1;
        check("ram_rbw_old", bus.dmem_data_out, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        bus.dmem_wren = 1'b0;
        rd("ram_rbw_new", 32'h10, 32'hCAFE_F00D);
        wr(32'h10, 32'hDEAD_BEEF);
        wr(32'h400, 32'h5555_5555);
        rd("ram_oob", 32'h400, 32'h0);
        rd("ram_no_alias", 32'h0, 32'h1111_1111);
        rd("unmapped", 32'h8000_0010, 32'h0);

        // Single TX push, no fall-through
        @(negedge clk);
        bus.dmem_wren    = 1'b1;
        bus.ALU_result   = TXDATA_ADDR;
        bus.dmem_data_in = 32'h0000_0141;
        #1;
        check("tx_nofallthru", {31'b0, bus.tx_valid}, 32'h0);
        @(posedge clk);
        #1;
        bus.dmem_wren = 1'b0;
        check("tx_valid1", {31'b0, bus.tx_valid}, 32'h1);
        check("tx_data1", {24'b0, bus.tx_data}, 32'h41);
        rd("tx_status1", STATUS_ADDR, 32'h0000_0100);
        rd("txdata_rd0", TXDATA_ADDR, 32'h0);
        bus.tx_ready = 1'b1;
        step();
        bus.tx_ready = 1'b0;
        check("tx_drained_v", {31'b0, bus.tx_valid}, 32'h0);
        check("tx_drained_d", {24'b0, bus.tx_data}, 32'h0);

        // Overflow then drain
        for (int i = 1; i <= 9; i++) wr(TXDATA_ADDR, i);
        rd("ovf_status", STATUS_ADDR, 32'h0000_0805);
        bus.tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("ovf_drain_v", {31'b0, bus.tx_valid}, 32'h1);
            check("ovf_drain_d", {24'b0, bus.tx_data}, i);
            step();
        end
        bus.tx_ready = 1'b0;
        check("ovf_empty_v", {31'b0, bus.tx_valid}, 32'h0);
        check("ovf_empty_d", {24'b0, bus.tx_data}, 32'h0);
        rd("ovf_sticky", STATUS_ADDR, 32'h0000_0006);
        wr(STATUS_ADDR, 32'hFFFF_FFFF);
        rd("ovf_clear", STATUS_ADDR, 32'h0000_0002);

        // Concurrent push/pop at count=3
        wr(TXDATA_ADDR, 32'h0A);
        wr(TXDATA_ADDR, 32'h0B);
        wr(TXDATA_ADDR, 32'h0C);
        rd("pp_count3", STATUS_ADDR, 32'h0000_0300);
        @(negedge clk);
        bus.dmem_wren    = 1'b1;
        bus.ALU_result   = TXDATA_ADDR;
        bus.dmem_data_in = 32'h0D;
        bus.tx_ready     = 1'b1;
        @(posedge clk);
        #1;
        bus.dmem_wren = 1'b0;
        bus.tx_ready  = 1'b0;
        rd("pp_count_same", STATUS_ADDR, 32'h0000_0300);
        bus.tx_ready = 1'b1;
        for (int i = 'h0B; i <= 'h0D; i++) begin
            check("pp_order", {24'b0, bus.tx_data}, i);
            step();
        end
        bus.tx_ready = 1'b0;
        check("pp_empty", {31'b0, bus.tx_valid}, 32'h0);

        // Push and pop while full: push dropped
        for (int i = 0; i < 8; i++) wr(TXDATA_ADDR, 32'h10 + i);
        rd("full_status", STATUS_ADDR, 32'h0000_0801);
        @(negedge clk);
        bus.dmem_wren    = 1'b1;
        bus.ALU_result   = TXDATA_ADDR;
        bus.dmem_data_in = 32'h18;
        bus.tx_ready     = 1'b1;
        @(posedge clk);
        #1;
        bus.dmem_wren = 1'b0;
        bus.tx_ready  = 1'b0;
        rd("full_pp_status", STATUS_ADDR, 32'h0000_0704);
        bus.tx_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            check("full_pp_order", {24'b0, bus.tx_data}, 32'h10 + i);
            step();
        end
        bus.tx_ready = 1'b0;
        check("full_pp_empty", {31'b0, bus.tx_valid}, 32'h0);
        wr(STATUS_ADDR, 32'h0);

        // CYCLE counter
`ifdef DMEM_CYCLE_CNT_EN
        wr(CYCLE_ADDR, 32'hFFFF_FFFE);
        rd("cyc_load", CYCLE_ADDR, 32'hFFFF_FFFE);
        step();
        rd("cyc_inc", CYCLE_ADDR, 32'hFFFF_FFFF);
        step();
        rd("cyc_wrap", CYCLE_ADDR, 32'h0000_0000);
        step();
        rd("cyc_after_wrap", CYCLE_ADDR, 32'h0000_0001);
`else
        wr(CYCLE_ADDR, 32'h0000_1234);
        rd("cyc_off", CYCLE_ADDR, 32'h0);
        step();
        rd("cyc_off2", CYCLE_ADDR, 32'h0);
`endif

        // Asynchronous reset mid-stream
        for (int i = 1; i <= 5; i++) wr(TXDATA_ADDR, 32'h20 + i);
        rd("prerst_status", STATUS_ADDR, 32'h0000_0500);
        check("prerst_data", {24'b0, bus.tx_data}, 32'h21);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", {31'b0, bus.tx_valid}, 32'h0);
        check("arst_data", {24'b0, bus.tx_data}, 32'h0);
        rd("arst_cycle", CYCLE_ADDR, 32'h0);
        step();
        step();
        @(negedge clk);
        reset = 1'b1;
        step();
        rd("postrst_status", STATUS_ADDR, 32'h0000_0002);
        rd("postrst_ram", 32'h10, 32'hDEAD_BEEF);
        check("postrst_valid", {31'b0, bus.tx_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
